// File: rtl/tv_recorder.sv
// tv_recorder -- synthesizable test-vector writer.
//
// Captures {sample_in, sample_out} tuples from a unit under test into an
// internal memory. The word layout is {inputs MSB-first, output LSB-last},
// which is the packed-binary format the vector-driven benches load. A bench
// or host reads the memory back word by word through rd_addr_i/rd_data_o.
//
// Optional build macro: TV_RECORDER_DEDUP_EN -- when defined, an accepted
// sample equal to the last word written in the current run is dropped.
//
// Ports:
//   clk_i           rising-edge clock
//   reset_i         asynchronous active-high reset
//   start_i         one-cycle pulse, begins a run (IDLE/DONE only)
//   num_vectors_i   vectors to capture, sampled on start (0 or >DEPTH -> DEPTH)
//   sample_valid_i  sample pair valid this cycle
//   sample_in_i     DUT input field
//   sample_out_i    DUT output field
//   sample_ready_o  recorder accepts a sample this cycle
//   rd_addr_i       readback address
//   rd_data_o       registered readback word (0 for rd_addr_i >= DEPTH)
//   count_o         vectors written in current/last run
//   busy_o          high while recording
//   done_o          high once the run has completed
//   full_o          count_o == DEPTH
module tv_recorder #(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 1,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [ADDR_W:0]         num_vectors_i,
  input  logic                    sample_valid_i,
  input  logic [IN_W-1:0]         sample_in_i,
  input  logic [OUT_W-1:0]        sample_out_i,
  output logic                    sample_ready_o,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  output logic [IN_W+OUT_W-1:0]   rd_data_o,
  output logic [ADDR_W:0]         count_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    full_o
);

  localparam int W = IN_W + OUT_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RECORD, S_DONE} state_t;

  state_t          state_q;
  logic [ADDR_W:0] count_q, target_q;
  logic            busy_q, done_q, full_q, ready_q;
  logic [W-1:0]    rd_data_q;
  logic [W-1:0]    mem [DEPTH];

  logic [W-1:0]    word;
  logic [ADDR_W:0] count_d, target_d;
  logic            start_ok, accept, drop, wr_en;

  assign word     = {sample_in_i, sample_out_i};
  assign start_ok = start_i && (state_q != S_RECORD);
  assign accept   = sample_valid_i && (state_q == S_RECORD);
  assign wr_en    = accept && !drop;
  assign count_d  = count_q + 1'b1;
  // Out-of-range requests clamp to the full memory.
  assign target_d = (num_vectors_i == '0 || num_vectors_i > DEPTH_C) ? DEPTH_C
                                                                     : num_vectors_i;

`ifdef TV_RECORDER_DEDUP_EN
  logic [W-1:0] last_q;
  logic         last_vld_q;

  // Repeat of the previous written word in this run is silently dropped;
  // the valid flag guarantees the first sample of a run is always kept.
  assign drop = last_vld_q && (word == last_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (start_ok) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (wr_en) begin
      last_q     <= word;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign drop = 1'b0;
`endif

  // Control FSM with registered status outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      target_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      full_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q  <= S_RECORD;
            count_q  <= '0;
            target_q <= target_d;
            busy_q   <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            full_q   <= 1'b0;
          end
        end
        S_RECORD: begin
          if (wr_en) begin
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            // Leave on the same edge as the final write.
            if (count_d == target_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Capture memory: not reset, contents survive across runs and resets.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[count_q[ADDR_W-1:0]] <= word;
  end

  // Registered read; nonblocking update gives read-before-write on collision.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      rd_data_q <= '0;
    else if ((ADDR_W+1)'(rd_addr_i) < DEPTH_C)
      rd_data_q <= mem[rd_addr_i];
    else
      rd_data_q <= '0;
  end

  assign sample_ready_o = ready_q;
  assign rd_data_o      = rd_data_q;
  assign count_o        = count_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign full_o         = full_q;

endmodule

// File: tb/tb_tv_recorder.sv
module tb_tv_recorder;

`ifdef TV_RECORDER_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic [5:0] num_vectors_i;
  logic       sample_valid_i;
  logic [1:0] sample_in_i;
  logic [0:0] sample_out_i;
  logic       sample_ready_o;
  logic [4:0] rd_addr_i;
  logic [2:0] rd_data_o;
  logic [5:0] count_o;
  logic       busy_o, done_o, full_o;

  int total = 0;
  int bad   = 0;

  tv_recorder #(.IN_W(2), .OUT_W(1), .DEPTH(32), .ADDR_W(5)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
    .num_vectors_i(num_vectors_i), .sample_valid_i(sample_valid_i),
    .sample_in_i(sample_in_i), .sample_out_i(sample_out_i),
    .sample_ready_o(sample_ready_o), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .count_o(count_o), .busy_o(busy_o),
    .done_o(done_o), .full_o(full_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit       st;
    bit [5:0] nv;
    bit       vld;
    bit [2:0] smp;
    bit [4:0] rd;
    bit [5:0] e_cnt;
    bit       e_rdy, e_busy, e_done, e_full;
    bit       chk_rd;
    bit [2:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input bit st, input int nv, input bit vld, input bit [2:0] smp,
                     input int rd, input int e_cnt, input bit e_rdy, input bit e_busy,
                     input bit e_done, input bit e_full, input bit chk_rd,
                     input bit [2:0] e_rd);
    vec_t v;
    v.st = st; v.nv = 6'(nv); v.vld = vld; v.smp = smp; v.rd = 5'(rd);
    v.e_cnt = 6'(e_cnt); v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_done = e_done;
    v.e_full = e_full; v.chk_rd = chk_rd; v.e_rd = e_rd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit st, input int nv, input bit vld, input bit [2:0] smp);
    start_i        = st;
    num_vectors_i  = 6'(nv);
    sample_valid_i = vld;
    {sample_in_i, sample_out_i} = smp;
  endtask

  initial begin
    int acc;
    reset_i = 1'b1;
    rd_addr_i = '0;
    drive(0, 0, 0, 3'b000);

    // NAND capture, num_vectors=4
    row(1,4,0,3'b000,0, 0,1,1,0,0, 0,3'b000);
    row(0,0,1,3'b001,0, 1,1,1,0,0, 0,3'b000);
    row(0,0,1,3'b011,0, 2,1,1,0,0, 0,3'b000);
    row(0,0,1,3'b101,0, 3,1,1,0,0, 0,3'b000);
    row(0,0,1,3'b110,0, 4,0,0,1,0, 0,3'b000);
    row(0,0,1,3'b111,0, 4,0,0,1,0, 0,3'b000); // ignored in DONE
    row(0,0,0,3'b000,0, 4,0,0,1,0, 1,3'b001);
    row(0,0,0,3'b000,1, 4,0,0,1,0, 1,3'b011);
    row(0,0,0,3'b000,2, 4,0,0,1,0, 1,3'b101);
    row(0,0,0,3'b000,3, 4,0,0,1,0, 1,3'b110);
    // start in DONE, then start during RECORD is ignored
    row(1,4,0,3'b000,0, 0,1,1,0,0, 0,3'b000);
    row(0,0,1,3'b000,0, 1,1,1,0,0, 0,3'b000);
    row(0,0,1,3'b010,0, 2,1,1,0,0, 0,3'b000);
    row(1,1,1,3'b100,0, 3,1,1,0,0, 0,3'b000);
    row(0,0,1,3'b111,0, 4,0,0,1,0, 0,3'b000);
    row(0,0,0,3'b000,2, 4,0,0,1,0, 1,3'b100);
    row(0,0,0,3'b000,3, 4,0,0,1,0, 1,3'b111);
    // gapped valid 1,0,0,1,1 with num_vectors=3
    row(1,3,0,3'b000,0, 0,1,1,0,0, 0,3'b000);
    row(0,0,1,3'b001,0, 1,1,1,0,0, 0,3'b000);
    row(0,0,0,3'b111,0, 1,1,1,0,0, 0,3'b000);
    row(0,0,0,3'b110,0, 1,1,1,0,0, 0,3'b000);
    row(0,0,1,3'b010,0, 2,1,1,0,0, 0,3'b000);
    row(0,0,1,3'b011,0, 3,0,0,1,0, 0,3'b000);
    // duplicate sample: 01/1, 01/1, 10/1 with num_vectors=2
    row(1,2,0,3'b000,0, 0,1,1,0,0, 0,3'b000);
    row(0,0,1,3'b011,0, 1,1,1,0,0, 0,3'b000);
    row(0,0,1,3'b011,0, DEDUP ? 1 : 2, DEDUP, DEDUP, !DEDUP, 0, 0,3'b000);
    row(0,0,1,3'b101,0, 2,0,0,1,0, 0,3'b000);
    row(0,0,0,3'b000,0, 2,0,0,1,0, 1,3'b011);
    row(0,0,0,3'b000,1, 2,0,0,1,0, 1,DEDUP ? 3'b101 : 3'b011);

    step(); step();
    chk("rst_count", count_o, 0);
    chk("rst_busy",  busy_o, 0);
    chk("rst_done",  done_o, 0);
    chk("rst_full",  full_o, 0);
    chk("rst_ready", sample_ready_o, 0);
    chk("rst_rd",    rd_data_o, 0);
    reset_i = 1'b0;
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].nv, vecs[i].vld, vecs[i].smp);
      rd_addr_i = vecs[i].rd;
      step();
      chk($sformatf("v%0d_count", i), count_o, vecs[i].e_cnt);
      chk($sformatf("v%0d_ready", i), sample_ready_o, vecs[i].e_rdy);
      chk($sformatf("v%0d_busy", i), busy_o, vecs[i].e_busy);
      chk($sformatf("v%0d_done", i), done_o, vecs[i].e_done);
      chk($sformatf("v%0d_full", i), full_o, vecs[i].e_full);
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rd", i), rd_data_o, vecs[i].e_rd);
    end
    drive(0, 0, 0, 3'b000);

    // num_vectors=0 -> DEPTH; 40 offered samples, only 32 accepted
    drive(1, 0, 0, 3'b000);
    step();
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      drive(0, 0, 1, 3'(k));
      if (sample_ready_o) acc++;
      step();
    end
    drive(0, 0, 0, 3'b000);
    chk("full_acc",   acc, 32);
    chk("full_count", count_o, 32);
    chk("full_full",  full_o, 1);
    chk("full_done",  done_o, 1);
    chk("full_ready", sample_ready_o, 0);
    rd_addr_i = 5'd31; step();
    chk("full_mem31", rd_data_o, 3'b111);
    rd_addr_i = 5'd30; step();
    chk("full_mem30", rd_data_o, 3'b110);

    // read-before-write collision at address 0 (old word is 000)
    rd_addr_i = 5'd0;
    drive(1, 2, 0, 3'b000); step();
    chk("rbw_full_clr", full_o, 0);
    drive(0, 0, 1, 3'b101); step();
    chk("rbw_old", rd_data_o, 3'b000);
    drive(0, 0, 1, 3'b110); step();
    chk("rbw_new", rd_data_o, 3'b101);
    chk("rbw_done", done_o, 1);
    drive(0, 0, 0, 3'b000);

    // reset mid-run aborts immediately
    drive(1, 4, 0, 3'b000); step();
    drive(0, 0, 1, 3'b001); step();
    drive(0, 0, 1, 3'b010); step();
    chk("abort_pre_count", count_o, 2);
    drive(0, 0, 0, 3'b000);
    #2 reset_i = 1'b1;
    #1;
    chk("abort_busy",  busy_o, 0);
    chk("abort_count", count_o, 0);
    chk("abort_ready", sample_ready_o, 0);
    chk("abort_rd",    rd_data_o, 0);
    step();
    reset_i = 1'b0;
    drive(1, 4, 0, 3'b000); step();
    chk("restart_busy", busy_o, 1);
    drive(0, 0, 1, 3'b111); step();
    drive(0, 0, 0, 3'b000);
    rd_addr_i = 5'd0; step();
    chk("restart_mem0", rd_data_o, 3'b111);
    chk("restart_count", count_o, 1);
    rd_addr_i = 5'd1; step();
    chk("restart_mem1", rd_data_o, 3'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
